// File: rtl/pbs_pkg.sv
// Shared constants for the battle engine: move table, LFSR taps and the
// datapath action encoding used to resolve simultaneous strobes.
package pbs_pkg;

  localparam logic [3:0] MOVE_POWER  [4] = '{4'd3, 4'd5, 4'd8, 4'd12};
  localparam logic [3:0] MOVE_THRESH [4] = '{4'd8, 4'd6, 4'd3, 4'd1};

  // Fibonacci taps 8,6,5,4 expressed as a mask over bits [7:0].
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_END,
    ACT_LOAD_PM,
    ACT_CALC_PH,
    ACT_APPLY_AD,
    ACT_LOAD_AM,
    ACT_CALC_AH,
    ACT_APPLY_PD
  } action_e;

  function automatic logic [3:0] move_power(input logic [1:0] m);
    return MOVE_POWER[m];
  endfunction

  function automatic logic [3:0] move_thresh(input logic [1:0] m);
    return MOVE_THRESH[m];
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; advances every cycle so that the
// moment a player presses go effectively randomizes the rolls.
module lfsr8
  import pbs_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] value
);

  always_ff @(posedge clk) begin
    if (reset) value <= SEED;
    else       value <= {value[6:0], ^(value & LFSR_TAPS)};
  end

endmodule

// File: rtl/battle_datapath.sv
// Battle datapath: HP, moves and hit result, advanced by edge-detected
// controller strobes, with a game-over freeze and restart on ld_pm.
module battle_datapath
  import pbs_pkg::*;
#(
  parameter int         HP_W      = 5,
  parameter int         MAX_HP    = 20,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      move_in,
  input  logic            ld_pm,
  input  logic            calc_ph,
  input  logic            apply_ad,
  input  logic            ld_am,
  input  logic            calc_ah,
  input  logic            apply_pd,
  input  logic            victory,
  input  logic            loss,
  output logic [HP_W-1:0] player_hp,
  output logic [HP_W-1:0] ai_hp,
  output logic [1:0]      player_move,
  output logic [1:0]      ai_move,
  output logic            hit,
  output logic [3:0]      damage,
  output logic            hp_is_zero,
  output logic            game_over
);

  localparam logic [HP_W-1:0] HP_START = HP_W'(MAX_HP);

  logic [7:0]      lfsr_q;
  logic [2:0]      unused_lfsr_bits;
  logic [6:0]      strobes;
  logic [6:0]      strobes_q;
  logic [6:0]      rise;
  action_e         act;
  logic [1:0]      attack_move;
  logic            roll_hit;
  logic [3:0]      dmg_now;
  logic [HP_W-1:0] dmg_ext;
  logic [HP_W-1:0] target_hp;
  logic [HP_W-1:0] hp_after;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr_q)
  );

  assign unused_lfsr_bits = lfsr_q[5:3];

  assign strobes = {apply_pd, calc_ah, ld_am, apply_ad, calc_ph, ld_pm, 1'b0} >> 1
                   | {6'd0, ld_pm};
  assign rise    = strobes & ~strobes_q;

  // Priority is decided on strobe levels; non-ld_pm strobes then act only on their rise.
  always_comb begin
    act = ACT_NONE;
    if (victory || loss)  act = ACT_END;
    else if (ld_pm)       act = ACT_LOAD_PM;
    else if (calc_ph)     act = rise[1] ? ACT_CALC_PH  : ACT_NONE;
    else if (apply_ad)    act = rise[2] ? ACT_APPLY_AD : ACT_NONE;
    else if (ld_am)       act = rise[3] ? ACT_LOAD_AM  : ACT_NONE;
    else if (calc_ah)     act = rise[4] ? ACT_CALC_AH  : ACT_NONE;
    else if (apply_pd)    act = rise[5] ? ACT_APPLY_PD : ACT_NONE;
  end

  // One roll comparator and one saturating subtractor serve both combatants.
  always_comb begin
    attack_move = player_move;
    target_hp   = ai_hp;
    if (act == ACT_CALC_AH || act == ACT_APPLY_PD) begin
      attack_move = ai_move;
      target_hp   = player_hp;
    end
    roll_hit = {1'b0, lfsr_q[2:0]} < move_thresh(attack_move);
    dmg_now  = hit ? move_power(attack_move) : 4'd0;
    dmg_ext  = HP_W'(dmg_now);
    hp_after = (target_hp > dmg_ext) ? (target_hp - dmg_ext) : '0;
  end

  assign hp_is_zero = (apply_ad && (ai_hp == '0)) || (apply_pd && (player_hp == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      strobes_q   <= '0;
      player_hp   <= HP_START;
      ai_hp       <= HP_START;
      player_move <= 2'd0;
      ai_move     <= 2'd0;
      hit         <= 1'b0;
      damage      <= 4'd0;
      game_over   <= 1'b0;
    end else begin
      strobes_q <= strobes;
      if (act == ACT_END) begin
        game_over <= 1'b1;
      end else if (game_over) begin
        if (act == ACT_LOAD_PM && rise[0]) begin
          player_hp   <= HP_START;
          ai_hp       <= HP_START;
          damage      <= 4'd0;
          hit         <= 1'b0;
          game_over   <= 1'b0;
          player_move <= move_in;
        end
      end else begin
        case (act)
          ACT_LOAD_PM:  player_move <= move_in;
          ACT_CALC_PH,
          ACT_CALC_AH:  hit <= roll_hit;
          ACT_LOAD_AM:  ai_move <= lfsr_q[7:6];
          ACT_APPLY_AD: begin
            damage <= dmg_now;
            ai_hp  <= hp_after;
          end
          ACT_APPLY_PD: begin
            damage    <= dmg_now;
            player_hp <= hp_after;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_battle_datapath.sv
// Self-checking bench for battle_datapath: table-driven player turns, a
// scoreboard of apply results, and hand-written game-over/reset sequences.
module tb_battle_datapath;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] move_in = 2'd0;
  logic       ld_pm = 0, calc_ph = 0, apply_ad = 0, ld_am = 0;
  logic       calc_ah = 0, apply_pd = 0, victory = 0, loss = 0;
  logic [4:0] player_hp, ai_hp;
  logic [1:0] player_move, ai_move;
  logic       hit, hp_is_zero, game_over;
  logic [3:0] damage;

  always #5 clk = ~clk;

  battle_datapath #(.HP_W(5), .MAX_HP(20), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .reset(reset), .move_in(move_in),
    .ld_pm(ld_pm), .calc_ph(calc_ph), .apply_ad(apply_ad), .ld_am(ld_am),
    .calc_ah(calc_ah), .apply_pd(apply_pd), .victory(victory), .loss(loss),
    .player_hp(player_hp), .ai_hp(ai_hp), .player_move(player_move),
    .ai_move(ai_move), .hit(hit), .damage(damage),
    .hp_is_zero(hp_is_zero), .game_over(game_over)
  );

  localparam logic [7:0] S_LDPM = 8'h01, S_CALCPH = 8'h02, S_APPLYAD = 8'h04,
                         S_LDAM = 8'h08, S_CALCAH = 8'h10, S_APPLYPD = 8'h20,
                         S_VIC  = 8'h40;

  logic [3:0] pow_t [4] = '{4'd3, 4'd5, 4'd8, 4'd12};
  logic [3:0] thr_t [4] = '{4'd8, 4'd6, 4'd3, 4'd1};

  int total = 0;
  int bad = 0;

  logic [7:0] lfsr_m;
  logic [4:0] exp_php, exp_aihp;
  logic [1:0] exp_pmove, exp_aimove;
  logic       exp_hit;
  logic [3:0] exp_dmg;

  typedef struct {
    logic [4:0] hp;
    logic [3:0] dmg;
    logic       hit;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [1:0] move;
    int         hold;
    logic [4:0] hp;
    logic [3:0] dmg;
    logic       zero;
  } vec_t;
  vec_t vecs[7];

  task automatic checkOutput(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) lfsr_m = 8'hA5;
    else       lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] s, input logic [1:0] mv);
    ld_pm = s[0]; calc_ph = s[1]; apply_ad = s[2]; ld_am = s[3];
    calc_ah = s[4]; apply_pd = s[5]; victory = s[6]; loss = s[7];
    move_in = mv;
  endtask

  function automatic logic [4:0] sat_sub(input logic [4:0] hp, input logic [3:0] d);
    return (hp > {1'b0, d}) ? hp - {1'b0, d} : 5'd0;
  endfunction

  function automatic logic predict_hit(input logic [1:0] mv);
    return {1'b0, lfsr_m[2:0]} < thr_t[mv];
  endfunction

  task automatic waitRoll(input logic [1:0] mv, input int want);
    for (int i = 0; i < 300 && want != -1 && predict_hit(mv) != want[0]; i++) step();
    if (want != -1) checkOutput("roll_wait", int'(predict_hit(mv)), want);
  endtask

  task automatic popCompare(input string tag, input logic [4:0] hp_act);
    sb_t e;
    if (sbq.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sbq.pop_front();
    checkOutput({tag, "_hp"}, hp_act, e.hp);
    checkOutput({tag, "_damage"}, damage, e.dmg);
    checkOutput({tag, "_hit"}, hit, e.hit);
  endtask

  task automatic playerTurn(input logic [1:0] mv, input int hold, input int want, input bit push);
    applyStimulus(S_LDPM, mv); step();
    exp_pmove = mv;
    checkOutput("player_move", player_move, exp_pmove);
    applyStimulus(8'h00, mv); step();
    waitRoll(mv, want);
    exp_hit = predict_hit(mv);
    applyStimulus(S_CALCPH, mv); step();
    checkOutput("p_hit", hit, exp_hit);
    applyStimulus(8'h00, mv); step();
    exp_dmg  = exp_hit ? pow_t[mv] : 4'd0;
    exp_aihp = sat_sub(exp_aihp, exp_dmg);
    if (push) sbq.push_back('{exp_aihp, exp_dmg, exp_hit});
    applyStimulus(S_APPLYAD, mv); step();
    checkOutput("ad_hp_is_zero", hp_is_zero, exp_aihp == 5'd0);
    for (int i = 1; i < hold; i++) step();
    popCompare("ad", ai_hp);
    applyStimulus(8'h00, mv); step();
  endtask

  task automatic aiTurn(input int hold, input int want, input bit mid_reset);
    exp_aimove = lfsr_m[7:6];
    applyStimulus(S_LDAM, 2'd0); step();
    checkOutput("ai_move", ai_move, exp_aimove);
    applyStimulus(8'h00, 2'd0); step();
    waitRoll(exp_aimove, want);
    exp_hit = predict_hit(exp_aimove);
    applyStimulus(S_CALCAH, 2'd0); step();
    checkOutput("a_hit", hit, exp_hit);
    applyStimulus(8'h00, 2'd0); step();
    exp_dmg = exp_hit ? pow_t[exp_aimove] : 4'd0;
    exp_php = sat_sub(exp_php, exp_dmg);
    sbq.push_back('{exp_php, exp_dmg, exp_hit});
    applyStimulus(S_APPLYPD, 2'd0); step();
    checkOutput("pd_hp_is_zero", hp_is_zero, exp_php == 5'd0);
    for (int i = 1; i < hold; i++) step();
    popCompare("pd", player_hp);
    if (mid_reset) begin
      reset = 1'b1; step();
      checkOutput("rst_player_hp", player_hp, 20);
      checkOutput("rst_ai_hp", ai_hp, 20);
      checkOutput("rst_hp_is_zero", hp_is_zero, 0);
      checkOutput("rst_damage", damage, 0);
      checkOutput("rst_ai_move", ai_move, 0);
      checkOutput("rst_lfsr", dut.lfsr_q, 8'hA5);
      reset = 1'b0;
      exp_php = 5'd20; exp_aihp = 5'd20; exp_pmove = 2'd0; exp_aimove = 2'd0;
      exp_hit = 1'b0; exp_dmg = 4'd0;
    end
    applyStimulus(8'h00, 2'd0); step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0] = '{2'd0, 5, 5'd17, 4'd3, 1'b0};
    vecs[1] = '{2'd0, 2, 5'd14, 4'd3, 1'b0};
    vecs[2] = '{2'd0, 2, 5'd11, 4'd3, 1'b0};
    vecs[3] = '{2'd0, 2, 5'd8,  4'd3, 1'b0};
    vecs[4] = '{2'd0, 2, 5'd5,  4'd3, 1'b0};
    vecs[5] = '{2'd0, 2, 5'd2,  4'd3, 1'b0};
    vecs[6] = '{2'd0, 3, 5'd0,  4'd3, 1'b1};

    lfsr_m = 8'hA5;
    applyStimulus(8'h00, 2'd0);
    reset = 1'b1;
    step(); step();
    checkOutput("reset_player_hp", player_hp, 20);
    checkOutput("reset_ai_hp", ai_hp, 20);
    checkOutput("reset_hit", hit, 0);
    checkOutput("reset_damage", damage, 0);
    checkOutput("reset_game_over", game_over, 0);
    checkOutput("reset_hp_is_zero", hp_is_zero, 0);
    checkOutput("reset_lfsr", dut.lfsr_q, 8'hA5);
    reset = 1'b0;
    exp_php = 5'd20; exp_aihp = 5'd20; exp_pmove = 2'd0; exp_aimove = 2'd0;
    exp_hit = 1'b0; exp_dmg = 4'd0;

    for (int v = 0; v < 7; v++) begin
      sbq.push_back('{vecs[v].hp, vecs[v].dmg, 1'b1});
      playerTurn(vecs[v].move, vecs[v].hold, -1, 1'b0);
      checkOutput("table_hp_model", int'(exp_aihp), vecs[v].hp);
    end
    checkOutput("ai_hp_floor", ai_hp, 0);

    applyStimulus(S_VIC, 2'd0); step();
    checkOutput("game_over_set", game_over, 1);
    applyStimulus(8'h00, 2'd0); step();
    applyStimulus(S_CALCPH, 2'd0); step();
    applyStimulus(8'h00, 2'd0); step();
    applyStimulus(S_APPLYAD, 2'd0); step();
    applyStimulus(8'h00, 2'd0); step();
    applyStimulus(S_LDAM, 2'd0); step();
    applyStimulus(8'h00, 2'd0); step();
    checkOutput("frozen_ai_hp", ai_hp, 0);
    checkOutput("frozen_damage", damage, 3);
    checkOutput("frozen_hit", hit, 1);
    checkOutput("frozen_ai_move", ai_move, exp_aimove);
    checkOutput("frozen_game_over", game_over, 1);

    applyStimulus(S_LDPM, 2'd2); step();
    checkOutput("restart_player_hp", player_hp, 20);
    checkOutput("restart_ai_hp", ai_hp, 20);
    checkOutput("restart_game_over", game_over, 0);
    checkOutput("restart_hit", hit, 0);
    checkOutput("restart_damage", damage, 0);
    checkOutput("restart_player_move", player_move, 2);
    exp_php = 5'd20; exp_aihp = 5'd20; exp_hit = 1'b0; exp_dmg = 4'd0; exp_pmove = 2'd2;
    applyStimulus(8'h00, 2'd2); step();

    playerTurn(2'd2, 2, 0, 1'b1);
    checkOutput("miss_ai_hp", ai_hp, 20);
    playerTurn(2'd3, 3, 1, 1'b1);
    checkOutput("move3_ai_hp", ai_hp, 8);

    aiTurn(2, -1, 1'b0);
    aiTurn(3, -1, 1'b0);

    exp_hit = predict_hit(exp_pmove);
    applyStimulus(S_CALCPH | S_APPLYAD, 2'd0); step();
    checkOutput("prio_hit", hit, exp_hit);
    checkOutput("prio_damage", damage, exp_dmg);
    checkOutput("prio_ai_hp", ai_hp, exp_aihp);
    applyStimulus(8'h00, 2'd0); step();

    aiTurn(2, 1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
